interval_timer_16b: RTL

INTERVAL_TIMER_16B -- requirements
Module: interval_timer_16b

---
 rtl/interval_timer_16b.sv | 65 ++++++
 1 files changed

// File: rtl/interval_timer_16b.sv
// interval_timer_16b: measures cycles between start and stop with a saturating 16-bit count
module interval_timer_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        ack,
  input  logic        clear,
  output logic [15:0] count,
  output logic        running,
  output logic        valid,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] count_nx;
  logic overflow_nx;
  // next-state, count and overflow; clear beats everything, each state samples only its own input
  always_comb begin
    state_nx = state;
    count_nx = count;
    overflow_nx = overflow;
    if (clear) begin
      state_nx = IDLE;
      count_nx = '0;
      overflow_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count_nx = '0;
          state_nx = start ? RUN : IDLE;
          overflow_nx = start ? 1'b0 : overflow;
        end
        RUN: begin
          state_nx = stop ? DONE : RUN;
          count_nx = (stop || count == 16'hFFFF) ? count : count + 16'd1;
          overflow_nx = overflow | (!stop && count == 16'hFFFF);
        end
        DONE: begin
          state_nx = ack ? IDLE : DONE;
          count_nx = ack ? '0 : count;
        end
        default: begin
          state_nx = IDLE;
          count_nx = '0;
          overflow_nx = 1'b0;
        end
      endcase
    end
  end
  // state and datapath registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      overflow <= overflow_nx;
    end
  end
  assign running = (state == RUN);
  assign valid = (state == DONE);
endmodule
